// File: rtl/nn_complex_sampler_if.sv
// nn_complex_sampler_if: control, level and event-handshake signals of the sampler
interface nn_complex_sampler_if #(
  parameter int CNT_WIDTH = 8
);
  logic w_in;
  logic en;
  logic clr_cnt;
  logic evt_ready;
  logic w_filt;
  logic rise_pulse;
  logic fall_pulse;
  logic evt_valid;
  logic evt_type;
  logic evt_ovf;
  logic [CNT_WIDTH-1:0] rise_cnt;
  logic [CNT_WIDTH-1:0] fall_cnt;
  logic [CNT_WIDTH-1:0] glitch_cnt;
  modport master (
    output w_in, en, clr_cnt, evt_ready,
    input  w_filt, rise_pulse, fall_pulse, evt_valid, evt_type, evt_ovf, rise_cnt, fall_cnt, glitch_cnt
  );
  modport slave (
    input  w_in, en, clr_cnt, evt_ready,
    output w_filt, rise_pulse, fall_pulse, evt_valid, evt_type, evt_ovf, rise_cnt, fall_cnt, glitch_cnt
  );
endinterface

// File: rtl/nn_complex_sampler.sv
// nn_complex_sampler: synchronizes and debounces a glitchy level, counting and handing off its edges
module nn_complex_sampler #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  nn_complex_sampler_if.slave bus
);
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;
  localparam logic [3:0] LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic s1_q, s2_q, w_filt_q, rise_q, fall_q, evt_valid_q, evt_type_q, evt_ovf_q;
  logic [CNT_WIDTH-1:0] rise_cnt_q, fall_cnt_q, glitch_cnt_q;
  logic done, rise, fall, glitch, load, drop;
  // filter next state and the edge/glitch strobes it produces this cycle
  always_comb begin
    done = cnt_q == LAST;
    rise = bus.en && state_q == PEND_HI && s2_q && done;
    fall = bus.en && state_q == PEND_LO && !s2_q && done;
    glitch = bus.en && ((state_q == PEND_HI && !s2_q) || (state_q == PEND_LO && s2_q));
    load = (rise || fall) && (!evt_valid_q || bus.evt_ready);
    drop = (rise || fall) && evt_valid_q && !bus.evt_ready;
    state_d = state_q;
    cnt_d = cnt_q;
    if (bus.en)
      case (state_q)
        STABLE_LO: begin
          state_d = s2_q ? PEND_HI : STABLE_LO;
          cnt_d = s2_q ? 4'd1 : 4'd0;
        end
        PEND_HI: begin
          state_d = !s2_q ? STABLE_LO : done ? STABLE_HI : PEND_HI;
          cnt_d = (s2_q && !done) ? cnt_q + 4'd1 : 4'd0;
        end
        STABLE_HI: begin
          state_d = !s2_q ? PEND_LO : STABLE_HI;
          cnt_d = !s2_q ? 4'd1 : 4'd0;
        end
        default: begin
          state_d = s2_q ? STABLE_HI : done ? STABLE_LO : PEND_LO;
          cnt_d = (!s2_q && !done) ? cnt_q + 4'd1 : 4'd0;
        end
      endcase
  end
  // synchronizer, filter state, saturating counters and the one-deep event slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q <= '0;
      w_filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      glitch_cnt_q <= '0;
      evt_valid_q <= 1'b0;
      evt_type_q <= 1'b0;
      evt_ovf_q <= 1'b0;
    end else begin
      s1_q <= bus.w_in;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      w_filt_q <= rise ? 1'b1 : fall ? 1'b0 : w_filt_q;
      rise_q <= rise;
      fall_q <= fall;
      rise_cnt_q <= bus.clr_cnt ? '0 : rise_cnt_q + CNT_WIDTH'(rise && rise_cnt_q != MAX);
      fall_cnt_q <= bus.clr_cnt ? '0 : fall_cnt_q + CNT_WIDTH'(fall && fall_cnt_q != MAX);
      glitch_cnt_q <= bus.clr_cnt ? '0 : glitch_cnt_q + CNT_WIDTH'(glitch && glitch_cnt_q != MAX);
      evt_valid_q <= load || (evt_valid_q && !bus.evt_ready);
      evt_type_q <= load ? rise : evt_type_q;
      evt_ovf_q <= !bus.clr_cnt && (evt_ovf_q || drop);
    end
  end
  assign bus.w_filt = w_filt_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.rise_cnt = rise_cnt_q;
  assign bus.fall_cnt = fall_cnt_q;
  assign bus.glitch_cnt = glitch_cnt_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_type = evt_type_q;
  assign bus.evt_ovf = evt_ovf_q;
endmodule

// File: tb/tb_nn_complex_sampler.sv
// tb_nn_complex_sampler: directed and random checks of two sampler instances against a level/run-length model
module tb_nn_complex_sampler;
  localparam int STABLE = 3;
  logic clk, rst;
  int checks = 0, errors = 0;
  bit m_s1, m_s2, m_lvl, m_rp, m_fp, m_v, m_t, m_ovf;
  int m_run, m_rc, m_fc, m_gc;
  nn_complex_sampler_if #(.CNT_WIDTH(8)) b1 ();
  nn_complex_sampler_if #(.CNT_WIDTH(2)) b2 ();
  assign b2.w_in = b1.w_in;
  assign b2.en = b1.en;
  assign b2.clr_cnt = b1.clr_cnt;
  assign b2.evt_ready = b1.evt_ready;
  nn_complex_sampler #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(8)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  nn_complex_sampler #(.STABLE_CYCLES(STABLE), .CNT_WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic int sat(int v, int mx);
    return v > mx ? mx : v;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    {m_s1, m_s2, m_lvl, m_rp, m_fp, m_v, m_t, m_ovf} = '0;
    m_run = 0; m_rc = 0; m_fc = 0; m_gc = 0;
  endtask
  // the filtered level flips once STABLE consecutive samples disagree with it;
  // a disagreeing run that ends early is a glitch
  task automatic model_edge();
    bit r, f, g, drop;
    r = 0; f = 0; g = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (b1.en) begin
      if (m_s2 != m_lvl) begin
        m_run++;
        if (m_run == STABLE) begin
          m_lvl = m_s2;
          r = m_lvl;
          f = !m_lvl;
          m_run = 0;
        end
      end else begin
        g = m_run > 0;
        m_run = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = b1.w_in;
    m_rp = r;
    m_fp = f;
    drop = (r || f) && m_v && !b1.evt_ready;
    if (b1.clr_cnt) begin
      m_rc = 0; m_fc = 0; m_gc = 0;
    end else begin
      m_rc += int'(r); m_fc += int'(f); m_gc += int'(g);
    end
    if ((r || f) && (!m_v || b1.evt_ready)) begin
      m_v = 1; m_t = r;
    end else if (b1.evt_ready) m_v = 0;
    m_ovf = !b1.clr_cnt && (m_ovf || drop);
  endtask
  task automatic check_all();
    chk("w_filt", b1.w_filt, m_lvl);
    chk("rise_pulse", b1.rise_pulse, m_rp);
    chk("fall_pulse", b1.fall_pulse, m_fp);
    chk("rise_cnt", b1.rise_cnt, sat(m_rc, 255));
    chk("fall_cnt", b1.fall_cnt, sat(m_fc, 255));
    chk("glitch_cnt", b1.glitch_cnt, sat(m_gc, 255));
    chk("evt_valid", b1.evt_valid, m_v);
    chk("evt_type", b1.evt_type, m_t);
    chk("evt_ovf", b1.evt_ovf, m_ovf);
    chk("w2_filt", b2.w_filt, m_lvl);
    chk("w2_rise_cnt", b2.rise_cnt, sat(m_rc, 3));
    chk("w2_fall_cnt", b2.fall_cnt, sat(m_fc, 3));
    chk("w2_glitch_cnt", b2.glitch_cnt, sat(m_gc, 3));
    chk("w2_evt_ovf", b2.evt_ovf, m_ovf);
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  initial begin
    int hold;
    rst = 1'b1;
    b1.w_in = 1'b0; b1.en = 1'b1; b1.clr_cnt = 1'b0; b1.evt_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    // accepted rise: w_filt at edge 4 after the capturing edge 0
    b1.w_in = 1'b1;
    tick();
    repeat (3) tick();
    chk("d_rise_pre_wfilt", b1.w_filt, 0);
    tick();
    chk("d_rise_wfilt", b1.w_filt, 1);
    chk("d_rise_pulse", b1.rise_pulse, 1);
    chk("d_rise_cnt", b1.rise_cnt, 1);
    chk("d_rise_valid", b1.evt_valid, 1);
    chk("d_rise_type", b1.evt_type, 1);
    tick();
    chk("d_rise_pulse_once", b1.rise_pulse, 0);
    // fall while the rise is still unconsumed: dropped, overflow set
    b1.w_in = 1'b0;
    repeat (6) tick();
    chk("d_ovf_wfilt", b1.w_filt, 0);
    chk("d_ovf_flag", b1.evt_ovf, 1);
    chk("d_ovf_type", b1.evt_type, 1);
    chk("d_ovf_fall_cnt", b1.fall_cnt, 1);
    b1.clr_cnt = 1'b1;
    tick();
    b1.clr_cnt = 1'b0;
    chk("d_clr_rise_cnt", b1.rise_cnt, 0);
    chk("d_clr_fall_cnt", b1.fall_cnt, 0);
    chk("d_clr_ovf", b1.evt_ovf, 0);
    chk("d_clr_valid", b1.evt_valid, 1);
    b1.evt_ready = 1'b1;
    tick();
    b1.evt_ready = 1'b0;
    chk("d_ready_clears", b1.evt_valid, 0);
    // two-sample pulse is rejected as a glitch
    b1.w_in = 1'b1;
    tick(); tick();
    b1.w_in = 1'b0;
    repeat (6) begin
      tick();
      chk("d_glitch_wfilt", b1.w_filt, 0);
      chk("d_glitch_pulse", b1.rise_pulse, 0);
      chk("d_glitch_valid", b1.evt_valid, 0);
    end
    chk("d_glitch_cnt", b1.glitch_cnt, 1);
    // disabled filter ignores a toggling input
    b1.en = 1'b0;
    repeat (10) begin
      b1.w_in = ~b1.w_in;
      tick();
      chk("d_en0_wfilt", b1.w_filt, 0);
      chk("d_en0_rise_cnt", b1.rise_cnt, 0);
      chk("d_en0_glitch_cnt", b1.glitch_cnt, 1);
      chk("d_en0_pulses", {b1.rise_pulse, b1.fall_pulse}, 0);
    end
    b1.w_in = 1'b0;
    repeat (3) tick();
    b1.en = 1'b1;
    // five accepted rises saturate the 2-bit counter
    b1.evt_ready = 1'b1;
    b1.clr_cnt = 1'b1;
    tick();
    b1.clr_cnt = 1'b0;
    repeat (5) begin
      b1.w_in = 1'b1;
      repeat (6) tick();
      b1.w_in = 1'b0;
      repeat (6) tick();
    end
    chk("d_sat_w2_rise", b2.rise_cnt, 3);
    chk("d_sat_w8_rise", b1.rise_cnt, 5);
    // asynchronous reset in the middle of a pending rise
    b1.w_in = 1'b1;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("d_rst_wfilt", b1.w_filt, 0);
    chk("d_rst_rise_cnt", b1.rise_cnt, 0);
    chk("d_rst_fall_cnt", b1.fall_cnt, 0);
    chk("d_rst_glitch_cnt", b1.glitch_cnt, 0);
    chk("d_rst_w2_rise_cnt", b2.rise_cnt, 0);
    check_all();
    tick();
    rst = 1'b0;
    tick();
    repeat (3) tick();
    chk("d_rst_restart_pre", b1.w_filt, 0);
    tick();
    chk("d_rst_restart_wfilt", b1.w_filt, 1);
    chk("d_rst_restart_pulse", b1.rise_pulse, 1);
    // random runs of input level, enable, ready and clear
    hold = 0;
    repeat (600) begin
      if (hold == 0) begin
        b1.w_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 6);
      end
      hold--;
      b1.en = $urandom_range(0, 9) != 0;
      b1.evt_ready = 1'($urandom_range(0, 1));
      b1.clr_cnt = $urandom_range(0, 19) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
